ncpu32k_wb_rr_arbiter: RTL

- Writeback-stage arbiter directly upstream of the ROB write port. Collects result beats from WAYS functional units (EPU, ALU, LPU, AGU, FPU, in that bit order) and selects one per cycle with round-robin fairness.
- Registers the selected beat into a single output stage. That stage drives the ROB writeback channel and the bypass network.
- Replaces fixed-priority selection so that a busy ALU cannot starve the AGU or FPU.

---
 rtl/ncpu32k_wb_rr_arbiter_pkg.sv | 21 ++
 rtl/ncpu32k_wb_rr_arbiter_if.sv | 38 +++
 rtl/ncpu32k_wb_rr_arbiter_pick.sv | 21 ++
 rtl/ncpu32k_wb_rr_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/ncpu32k_wb_rr_arbiter_pkg.sv
// Shared definitions for the writeback round-robin arbiter: tag layout and
// functional-unit way indices (bit order of the per-FU vectors).
package ncpu32k_wb_rr_arbiter_pkg;

    // Tag layout: {branch_op, exc[3:0]}
    localparam int TAG_EXC_W     = 4;
    localparam int TAG_BRANCH_OP = 4;

    typedef struct packed {
        logic                 branch_op;
        logic [TAG_EXC_W-1:0] exc;
    } wb_tag_t;

    // Writeback way indices; way 0 is the reset-time highest priority
    localparam int WB_WAY_EPU = 0;
    localparam int WB_WAY_ALU = 1;
    localparam int WB_WAY_LPU = 2;
    localparam int WB_WAY_AGU = 3;
    localparam int WB_WAY_FPU = 4;

endpackage

// File: rtl/ncpu32k_wb_rr_arbiter_if.sv
// Writeback bus between the functional units, the arbiter and the ROB.
// "slave" is the arbiter's view; "master" is the FU/ROB environment's view.
interface ncpu32k_wb_rr_arbiter_if
    import ncpu32k_wb_rr_arbiter_pkg::*;
#(
    parameter int WAYS      = 5,
    parameter int DW        = 32,
    parameter int TAG_WIDTH = 5,
    parameter int ID_WIDTH  = 4
);
    // Functional-unit side
    logic [WAYS-1:0]           fu_wb_BVALID;
    logic [WAYS-1:0]           fu_wb_BREADY;
    logic [WAYS*DW-1:0]        fu_wb_BDATA;
    logic [WAYS*TAG_WIDTH-1:0] fu_wb_BTAG;
    logic [WAYS*ID_WIDTH-1:0]  fu_wb_id;

    // ROB side
    logic                      rob_wb_BVALID;
    logic                      rob_wb_BREADY;
    logic [DW-1:0]             rob_wb_BDATA;
    logic [TAG_WIDTH-1:0]      rob_wb_BTAG;
    logic [ID_WIDTH-1:0]       rob_wb_id;
    logic [WAYS-1:0]           rob_wb_way;

    modport slave (
        input  fu_wb_BVALID, fu_wb_BDATA, fu_wb_BTAG, fu_wb_id, rob_wb_BREADY,
        output fu_wb_BREADY, rob_wb_BVALID, rob_wb_BDATA, rob_wb_BTAG,
               rob_wb_id, rob_wb_way
    );

    modport master (
        output fu_wb_BVALID, fu_wb_BDATA, fu_wb_BTAG, fu_wb_id, rob_wb_BREADY,
        input  fu_wb_BREADY, rob_wb_BVALID, rob_wb_BDATA, rob_wb_BTAG,
               rob_wb_id, rob_wb_way
    );

endinterface

// File: rtl/ncpu32k_wb_rr_arbiter_pick.sv
// Combinational one-hot round-robin picker. The request vector is doubled so
// that the search starting at the priority bit wraps around naturally; the
// subtraction clears the first request at or above prio and the AND keeps it.
module ncpu32k_rr_pick
    import ncpu32k_wb_rr_arbiter_pkg::*;
#(
    parameter int WAYS = 5
) (
    input  logic [WAYS-1:0] req,
    input  logic [WAYS-1:0] prio,
    output logic [WAYS-1:0] gnt
);

    logic [2*WAYS-1:0] dbl_req_s;
    logic [2*WAYS-1:0] dbl_gnt_s;

    assign dbl_req_s = {req, req};
    assign dbl_gnt_s = dbl_req_s & ~(dbl_req_s - {{WAYS{1'b0}}, prio});
    assign gnt       = dbl_gnt_s[WAYS-1:0] | dbl_gnt_s[2*WAYS-1:WAYS];

endmodule

// File: rtl/ncpu32k_wb_rr_arbiter.sv
// Writeback-stage arbiter: picks one FU result per cycle with round-robin
// fairness and registers it into a single output stage feeding the ROB
// write port and the bypass network.
module ncpu32k_wb_rr_arbiter
    import ncpu32k_wb_rr_arbiter_pkg::*;
#(
    parameter int WAYS      = 5,
    parameter int DW        = 32,
    parameter int TAG_WIDTH = 5,
    parameter int ID_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    ncpu32k_wb_rr_arbiter_if.slave bus
);

    localparam logic [WAYS-1:0] PRIO_RST = WAYS'(1) << WB_WAY_EPU;

    logic [WAYS-1:0]      prio_ptr_r;
    logic [WAYS-1:0]      gnt_s;
    logic [WAYS-1:0]      fu_bready_s;
    logic                 out_free_s;
    logic                 grant_en_s;
    logic                 accept_s;

    logic [DW-1:0]        sel_data_s;
    logic [TAG_WIDTH-1:0] sel_tag_s;
    logic [ID_WIDTH-1:0]  sel_id_s;

    logic                 rob_valid_r;
    logic [DW-1:0]        rob_data_r;
    logic [TAG_WIDTH-1:0] rob_tag_r;
    logic [ID_WIDTH-1:0]  rob_id_r;
    logic [WAYS-1:0]      rob_way_r;

    ncpu32k_rr_pick #(
        .WAYS (WAYS)
    ) u_pick (
        .req  (bus.fu_wb_BVALID),
        .prio (prio_ptr_r),
        .gnt  (gnt_s)
    );

    // The output stage can take a new beat when empty or draining this cycle;
    // reset and flush suppress any grant so nothing is lost from an FU.
    assign out_free_s  = ~rob_valid_r | bus.rob_wb_BREADY;
    assign grant_en_s  = out_free_s & ~flush & ~rst;
    assign fu_bready_s = grant_en_s ? gnt_s : {WAYS{1'b0}};
    assign accept_s    = |fu_bready_s;

    assign bus.fu_wb_BREADY  = fu_bready_s;
    assign bus.rob_wb_BVALID = rob_valid_r;
    assign bus.rob_wb_BDATA  = rob_data_r;
    assign bus.rob_wb_BTAG   = rob_tag_r;
    assign bus.rob_wb_id     = rob_id_r;
    assign bus.rob_wb_way    = rob_way_r;

    // One-hot AND-OR mux of the granted way's payload.
    always_comb begin
        sel_data_s = {DW{1'b0}};
        sel_tag_s  = {TAG_WIDTH{1'b0}};
        sel_id_s   = {ID_WIDTH{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            sel_data_s = sel_data_s | (bus.fu_wb_BDATA[i*DW +: DW] & {DW{gnt_s[i]}});
            sel_tag_s  = sel_tag_s  | (bus.fu_wb_BTAG[i*TAG_WIDTH +: TAG_WIDTH] & {TAG_WIDTH{gnt_s[i]}});
            sel_id_s   = sel_id_s   | (bus.fu_wb_id[i*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{gnt_s[i]}});
        end
    end

    // Priority pointer moves to the way just after the accepted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr_r <= PRIO_RST;
        end else if (accept_s) begin
            prio_ptr_r <= {fu_bready_s[WAYS-2:0], fu_bready_s[WAYS-1]};
        end else begin
            prio_ptr_r <= prio_ptr_r;
        end
    end

    // Output stage: load on accept, empty on ROB take or flush, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rob_valid_r <= 1'b0;
            rob_data_r  <= {DW{1'b0}};
            rob_tag_r   <= {TAG_WIDTH{1'b0}};
            rob_id_r    <= {ID_WIDTH{1'b0}};
            rob_way_r   <= {WAYS{1'b0}};
        end else if (flush) begin
            rob_valid_r <= 1'b0;
        end else if (accept_s) begin
            rob_valid_r <= 1'b1;
            rob_data_r  <= sel_data_s;
            rob_tag_r   <= sel_tag_s;
            rob_id_r    <= sel_id_s;
            rob_way_r   <= fu_bready_s;
        end else if (bus.rob_wb_BREADY) begin
            rob_valid_r <= 1'b0;
        end else begin
            rob_valid_r <= rob_valid_r;
        end
    end

endmodule
